counter_seq_ctrl: RTL and testbench

//   Sequencer for the 8-bit up/down counter. Accepts move/sweep commands over a

---
 rtl/counter_seq_ctrl.sv | 95 +++++++++
 tb/tb_counter_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencer for an up/down counter.
// Accepts move/sweep commands over a valid/ready handshake and steps the
// counter one LSB per cycle until it reaches the goal. It optionally sweeps
// back and forth between target and origin for cmd_passes extra legs.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_target, cmd_passes  goal value and extra sweep legs (0 = plain move)
//   abort                   cancel the active command
//   count_in                live counter value (closes the loop)
//   cnt_en, cnt_dn          counter enable and direction (1 = down)
//   busy                    command in progress
//   done, aborted           registered 1-cycle completion/cancel pulses
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [PW-1:0]    cmd_passes,
  input  logic             abort,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_dn,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] goal, origin;
  logic [PW-1:0]    passes_rem;
  logic             arrive;
  logic             idle_rdy;

  assign arrive = (count_in == goal);
  // Held low while reset is asserted so every output reads 0 in reset.
  assign cmd_ready = idle_rdy & rst_n;

  always_comb begin
    state_nxt = state;
    idle_rdy  = 1'b0;
    cnt_en    = 1'b0;
    cnt_dn    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        idle_rdy = 1'b1;
        if (cmd_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Direction from magnitude compare: the count never wraps.
        cnt_en = ~arrive & ~abort;
        cnt_dn = (count_in > goal);
        if (abort)
          state_nxt = IDLE;
        else if (arrive && passes_rem == '0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      goal       <= '0;
      origin     <= '0;
      passes_rem <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= (state == RUN) && !abort && arrive && (passes_rem == '0);
      aborted <= (state == RUN) && abort;
      if (state == IDLE && cmd_valid) begin
        goal       <= cmd_target;
        origin     <= count_in;
        passes_rem <= cmd_passes;
      end else if (state == RUN && !abort && arrive && passes_rem != '0) begin
        // Leg turnaround: the arrival cycle itself is the 1-cycle dwell.
        goal       <= origin;
        origin     <= goal;
        passes_rem <= passes_rem - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 8-bit up/down
// counter closing the loop. Each task drives one scenario and checks it.
module tb_counter_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int PW     = 4;
  localparam int BUDGET = 600;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic [PW-1:0]    cmd_passes;
  logic             abort;
  logic [WIDTH-1:0] count_in;
  logic             cnt_en, cnt_dn, busy, done, aborted;

  // counter model with a bench-side load port
  logic             ld;
  logic [WIDTH-1:0] ld_val;

  int checks = 0;
  int errors = 0;

  // results of the last run_cmd
  int en_cyc, dn_cyc, run_cyc, done_cyc, done_cnt, abort_cyc, abort_cnt;
  int ready_bad, en_at_abort;
  bit timed_out;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld)          count_in <= ld_val;
    else if (cnt_en) count_in <= cnt_dn ? count_in - 8'd1 : count_in + 8'd1;
  end

  counter_seq_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_passes(cmd_passes),
    .abort     (abort),
    .count_in  (count_in),
    .cnt_en    (cnt_en),
    .cnt_dn    (cnt_dn),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  task automatic load_count(input logic [WIDTH-1:0] v);
    @(negedge clk);
    ld = 1'b1; ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Offers a command right now (caller sits just after a negedge) and
  // monitors cycles 1.. after the accepting edge until done or aborted.
  task automatic run_cmd(input logic [WIDTH-1:0] tgt, input logic [PW-1:0] p,
                         input int abort_at);
    en_cyc = 0; dn_cyc = 0; run_cyc = 0; done_cyc = 0; done_cnt = 0;
    abort_cyc = 0; abort_cnt = 0; ready_bad = 0; en_at_abort = 0;
    timed_out = 1'b1;
    cmd_valid = 1'b1; cmd_target = tgt; cmd_passes = p;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = (i == abort_at);
      #1;
      if (cnt_en) en_cyc++;
      if (cnt_en && cnt_dn) dn_cyc++;
      if (busy) run_cyc++;
      if (cmd_ready === busy) ready_bad++;
      if (abort && cnt_en) en_at_abort++;
      if (done)    begin done_cnt++;  done_cyc = i;  end
      if (aborted) begin abort_cnt++; abort_cyc = i; end
      if (done || aborted) begin timed_out = 1'b0; break; end
    end
    abort = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL timeout tgt=%0d: no done/aborted within %0d cycles", tgt, BUDGET);
    end
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_after: done=%b aborted=%b busy=%b ready=%b need 0 0 0 1",
               name, done, aborted, busy, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; #1;
    checks++;
    if ({cmd_ready, cnt_en, cnt_dn, busy, done, aborted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b need 000000",
               {cmd_ready, cnt_en, cnt_dn, busy, done, aborted});
    end
    load_count(8'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b need 1 0", cmd_ready, busy);
    end
    // abort in IDLE does nothing
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort: aborted=%b busy=%b need 0 0", aborted, busy);
    end
  endtask

  task automatic test_move_up;
    load_count(8'd0);
    run_cmd(8'd5, 4'd0, 0);
    checks++;
    if (en_cyc != 5 || dn_cyc != 0 || count_in !== 8'd5) begin
      errors++;
      $display("FAIL t1_steps: en=%0d dn=%0d count=%0d need 5 0 5", en_cyc, dn_cyc, count_in);
    end
    checks++;
    if (done_cyc != 7 || run_cyc != 6 || ready_bad != 0) begin
      errors++;
      $display("FAIL t1_timing: done@%0d run=%0d ready_bad=%0d need 7 6 0",
               done_cyc, run_cyc, ready_bad);
    end
    check_quiet("t1");
  endtask

  task automatic test_move_down;
    load_count(8'd10);
    run_cmd(8'd7, 4'd0, 0);
    checks++;
    if (en_cyc != 3 || dn_cyc != 3 || count_in !== 8'd7 || done_cyc != 5) begin
      errors++;
      $display("FAIL t2_down: en=%0d dn=%0d count=%0d done@%0d need 3 3 7 5",
               en_cyc, dn_cyc, count_in, done_cyc);
    end
    check_quiet("t2");
  endtask

  task automatic test_zero_dist;
    load_count(8'd42);
    run_cmd(8'd42, 4'd0, 0);
    checks++;
    if (en_cyc != 0 || run_cyc != 1 || done_cyc != 2 || count_in !== 8'd42) begin
      errors++;
      $display("FAIL t3_zero: en=%0d run=%0d done@%0d count=%0d need 0 1 2 42",
               en_cyc, run_cyc, done_cyc, count_in);
    end
  endtask

  task automatic test_sweep;
    load_count(8'd3);
    run_cmd(8'd6, 4'd2, 0);
    checks++;
    if (en_cyc != 9 || dn_cyc != 3 || count_in !== 8'd6) begin
      errors++;
      $display("FAIL t4_sweep: en=%0d dn=%0d count=%0d need 9 3 6", en_cyc, dn_cyc, count_in);
    end
    checks++;
    if (run_cyc != 12 || done_cyc != 13) begin
      errors++;
      $display("FAIL t4_timing: run=%0d done@%0d need 12 13", run_cyc, done_cyc);
    end
    check_quiet("t4");
  endtask

  task automatic test_abort;
    load_count(8'd0);
    run_cmd(8'd200, 4'd0, 20);
    checks++;
    if (en_cyc != 19 || en_at_abort != 0 || count_in !== 8'd19) begin
      errors++;
      $display("FAIL t5_freeze: en=%0d en_at_abort=%0d count=%0d need 19 0 19",
               en_cyc, en_at_abort, count_in);
    end
    checks++;
    if (abort_cnt != 1 || abort_cyc != 21 || done_cnt != 0) begin
      errors++;
      $display("FAIL t5_pulse: aborted=%0d @%0d done=%0d need 1 21 0",
               abort_cnt, abort_cyc, done_cnt);
    end
    check_quiet("t5");
    run_cmd(8'd25, 4'd0, 0);
    checks++;
    if (en_cyc != 6 || count_in !== 8'd25 || done_cyc != 8) begin
      errors++;
      $display("FAIL t5_next: en=%0d count=%0d done@%0d need 6 25 8",
               en_cyc, count_in, done_cyc);
    end
  endtask

  task automatic test_reset_mid;
    load_count(8'd3);
    cmd_valid = 1'b1; cmd_target = 8'd6; cmd_passes = 4'd3;
    @(negedge clk); cmd_valid = 1'b0;   // cycle 1
    repeat (5) @(negedge clk);          // cycle 6: second leg, going down
    #1;
    checks++;
    if (busy !== 1'b1 || cnt_en !== 1'b1 || cnt_dn !== 1'b1 || count_in !== 8'd5) begin
      errors++;
      $display("FAIL t6_pre: busy=%b en=%b dn=%b count=%0d need 1 1 1 5",
               busy, cnt_en, cnt_dn, count_in);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({cmd_ready, cnt_en, cnt_dn, busy, done, aborted} !== 6'b0) begin
      errors++;
      $display("FAIL t6_reset: got %b need 000000",
               {cmd_ready, cnt_en, cnt_dn, busy, done, aborted});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL t6_release: ready=%b done=%b aborted=%b need 1 0 0",
               cmd_ready, done, aborted);
    end
    test_move_up();
  endtask

  task automatic test_back_to_back;
    load_count(8'd250);
    run_cmd(8'd2, 4'd0, 0);
    checks++;
    if (en_cyc != 248 || dn_cyc != 248 || count_in !== 8'd2 || done_cyc != 250) begin
      errors++;
      $display("FAIL t7_nowrap: en=%0d dn=%0d count=%0d done@%0d need 248 248 2 250",
               en_cyc, dn_cyc, count_in, done_cyc);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL t7_ready_in_done: ready=%b need 1", cmd_ready);
    end
    // offered in the done cycle itself
    run_cmd(8'd4, 4'd0, 0);
    checks++;
    if (en_cyc != 2 || dn_cyc != 0 || count_in !== 8'd4 || done_cyc != 4) begin
      errors++;
      $display("FAIL t7_b2b: en=%0d dn=%0d count=%0d done@%0d need 2 0 4 4",
               en_cyc, dn_cyc, count_in, done_cyc);
    end
    check_quiet("t7");
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_target = '0; cmd_passes = '0; abort = 1'b0;
    ld = 1'b0; ld_val = '0; count_in = '0;
    test_reset();
    test_move_up();
    test_move_down();
    test_zero_dist();
    test_sweep();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
